mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer sharing the single `data_memory` instance between the instruction cache and the data cache of the 5-stage MIPS core. Accepts line-sized (128-bit) read requests from the I-cache and read/write requests from the D-cache. Serializes them onto the memory port and drives the memory's access-latency `count`. Returns a one-cycle acknowledge with read data to the winning requester.

## Interface
Parameters:
- `LATENCY`, default 10: memory access cycles per transaction; legal range 1–31.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ic_req`  in  1  I-cache line-read request; held until `ic_ack`.
- `ic_addr`  in  32  I-cache byte address.
- `ic_ack`  out  1  one-cycle pulse: I-cache transaction complete.
- `ic_rdata`  out  128  line read for I-cache; valid while `ic_ack`=1.
- `dc_req`  in  1  D-cache request; held until `dc_ack`.
- `dc_we`  in  1  D-cache op: 1 = line write-back, 0 = line fill.
- `dc_addr`  in  32  D-cache byte address.
- `dc_wdata`  in  128  D-cache write-back line.
- `dc_ack`  out  1  one-cycle pulse: D-cache transaction complete.
- `dc_rdata`  out  128  line read for D-cache; valid while `dc_ack`=1.
- `mem_read_address`  out  32  line-aligned read address to `data_memory`.
- `mem_write_address`  out  32  line-aligned write address to `data_memory`.
- `mem_write_data`  out  128  write line to `data_memory`.
- `mem_write`  out  1  write strobe; commits on the edge ending the cycle.
- `count`  out  5  elapsed cycles of the current access (0..LATENCY-1).
- `mem_read_data`  in  128  line returned by `data_memory`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - If neither request is high, remain in IDLE.
  - Otherwise choose a winner (see Configuration).
  - Latch the winner's id, op (I-cache is always a read), the address with bits [3:0] forced to 0, and the write data.
  - Set `count`<=0 and move to ACCESS.
- **ACCESS**
  - `count` increments by 1 each cycle.
  - The cycle with `count`==LATENCY-1 is the final cycle:
    - for a write, `mem_write`=1 in this cycle only;
    - for a read, `mem_read_data` is captured into the winner's rdata register at the end of this cycle.
  - After the final cycle, move to DONE.
- **DONE**
  - The winner's ack is 1 (registered) for exactly one cycle, then the FSM returns to IDLE.
- Memory address outputs hold the latched address for the whole of ACCESS and hold their last value otherwise.
- `mem_write_data` is driven only from the latched D-cache line.
- Requester contract:
  - `*_addr`, `dc_we` and `dc_wdata` are stable while `*_req` is high.
  - `*_req` drops on the edge that ends the ack cycle, so it is already low in the following IDLE cycle.
  - A request still high in IDLE after its ack is treated as a new transaction.
- Requests arriving during ACCESS or DONE wait; they are never lost.
- `*_rdata` holds its last captured value between acks. After a D-cache write, `dc_rdata` is unchanged.

## Timing
- `req` is sampled in IDLE at cycle N. ACCESS occupies cycles N+1..N+LATENCY. Ack is high at cycle N+LATENCY+1.
- Latency from request to ack is LATENCY+1 cycles. Throughput is one transaction per LATENCY+2 cycles.
- With back-to-back requests, the next grant is decided in the IDLE cycle at N+LATENCY+2.
- Simultaneous `ic_req` and `dc_req` in IDLE: exactly one is granted. The loser is granted in the next IDLE cycle if it is still requesting.
- Reset values:
  - state IDLE;
  - `ic_ack`, `dc_ack`, `mem_write`, `busy` = 0;
  - `count` = 0;
  - both rdata, all address and write-data outputs = 0;
  - last-grant register = I-cache.
- Reset mid-transaction aborts immediately. A write that has not reached its final cycle is not performed, and no ack is issued.
- LATENCY=1: ACCESS lasts one cycle with `count`=0, and that cycle is the final cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin grant. On contention, the requester not granted last wins. The last-grant register updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, D-cache always wins contention. The last-grant register is absent. Under continuous D-cache traffic the I-cache can starve; this is accepted.

## Structure
- Shared package `mips_mem_pkg` holds:
  - `LINE_W`=128, `ADDR_W`=32, `CNT_W`=5;
  - the FSM state enum `arb_state_t` (IDLE, ACCESS, DONE);
  - requester id enum `arb_id_t` (ARB_IC, ARB_DC).
- One sub-module, `arb_grant`: combinational winner selection from `ic_req`, `dc_req` and the last-grant register, containing the `MEM_ARB_RR_EN` branch.
- Everything else (FSM, counter, latches) lives in `mem_arbiter`.

## Test plan
- I-cache read alone, LATENCY=10, `ic_addr`=0x0000_0024 → `mem_read_address`=0x0000_0020 during ACCESS; `ic_ack` one cycle at N+11 with `ic_rdata`=memory line; `dc_ack` stays 0.
- D-cache write, `dc_addr`=0x40, `dc_wdata`=128'h9 → `mem_write`=1 only when `count`=9. A following D-cache read of 0x40 returns 128'h9.
- `ic_req` and `dc_req` both raised in the same IDLE cycle:
  - undefined: `dc_ack` first, `ic_ack` LATENCY+2 cycles later;
  - defined `MEM_ARB_RR_EN`, after reset: D-cache first, then I-cache. Repeating the contention alternates the winner.
- `rst` asserted while `count`=5 of a D-cache write → next cycle: IDLE, `count`=0, `busy`=0, no `mem_write` pulse, no ack. Memory contents are unchanged.
- LATENCY=1 read → ack 2 cycles after `req`.
- Continuous I-cache requests → acks every 3 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the I-cache/D-cache memory arbiter.
package mips_mem_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_IC = 1'b0,
        ARB_DC = 1'b1
    } arb_id_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_W / 8 - 1);
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Winner selection between I-cache and D-cache requests.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise the D-cache always wins.
module arb_grant
    import mips_mem_pkg::*;
(
    input  logic    ic_req_i,
    input  logic    dc_req_i,
`ifdef MEM_ARB_RR_EN
    input  arb_id_t last_grant_i,
`endif
    output logic    grant_valid_o,
    output arb_id_t grant_id_o
);

    always_comb begin
        grant_valid_o = ic_req_i | dc_req_i;
        grant_id_o    = ARB_IC;
        if (ic_req_i && dc_req_i) begin
`ifdef MEM_ARB_RR_EN
            grant_id_o = (last_grant_i == ARB_IC) ? ARB_DC : ARB_IC;
`else
            grant_id_o = ARB_DC;
`endif
        end else if (dc_req_i) begin
            grant_id_o = ARB_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache line reads and D-cache line fills/write-backs onto data_memory.
// Build option MEM_ARB_RR_EN: round-robin arbitration with a last-grant register.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [LINE_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic [CNT_W-1:0]  count,
    input  logic [LINE_W-1:0] mem_read_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    arb_state_t        state_q, state_d;
    arb_id_t           id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ic_ack_q, ic_ack_d;
    logic              dc_ack_q, dc_ack_d;
    logic              grant_valid;
    arb_id_t           grant_id;
    logic              final_cyc;

`ifdef MEM_ARB_RR_EN
    arb_id_t           last_q, last_d;
`endif

    arb_grant u_grant (
        .ic_req_i      (ic_req),
        .dc_req_i      (dc_req),
`ifdef MEM_ARB_RR_EN
        .last_grant_i  (last_q),
`endif
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign final_cyc = (state_q == ACCESS) && (count_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        count_d    = count_q;
        ic_ack_d   = 1'b0;
        dc_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    id_d    = grant_id;
                    count_d = '0;
                    state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant_id;
`endif
                    if (grant_id == ARB_DC) begin
                        we_d    = dc_we;
                        wdata_d = dc_wdata;
                        if (dc_we) wr_addr_d = line_align(dc_addr);
                        else       rd_addr_d = line_align(dc_addr);
                    end else begin
                        we_d      = 1'b0;
                        rd_addr_d = line_align(ic_addr);
                    end
                end
            end
            ACCESS: begin
                if (final_cyc) begin
                    state_d = DONE;
                    count_d = '0;
                    // Read data is captured on the edge that ends the final access cycle.
                    if (!we_q) begin
                        if (id_q == ARB_DC) dc_rdata_d = mem_read_data;
                        else                ic_rdata_d = mem_read_data;
                    end
                    if (id_q == ARB_DC) dc_ack_d = 1'b1;
                    else                ic_ack_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= ARB_IC;
            we_q       <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            count_q    <= '0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= ARB_IC;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            count_q    <= count_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign ic_ack            = ic_ack_q;
    assign dc_ack            = dc_ack_q;
    assign ic_rdata          = ic_rdata_q;
    assign dc_rdata          = dc_rdata_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wdata_q;
    assign mem_write         = final_cyc & we_q;
    assign count             = count_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-timing model.
module tb_mem_arbiter;

    localparam int L = 10;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    // Second contention follows a solo D-cache grant: round-robin then favours the I-cache.
    localparam int EXP_IC2 = RR ? L + 1 : 2 * L + 3;
    localparam int EXP_DC2 = RR ? 2 * L + 3 : L + 1;

    localparam logic [127:0] LINE_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] LINE_B = 128'h5555_aaaa_5555_aaaa_1234_5678_9abc_def0;
    localparam logic [127:0] LINE_C = 128'hc0de_0001_c0de_0002_c0de_0003_c0de_0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         ic_req, dc_req, dc_we;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wdata;
    logic         ic_ack, dc_ack, mem_write, busy;
    logic [127:0] ic_rdata, dc_rdata, mem_write_data, mem_read_data;
    logic [31:0]  mem_read_address, mem_write_address;
    logic [4:0]   count;

    logic [127:0] env_mem [16];
    assign mem_read_data = env_mem[mem_read_address[7:4]];

    mem_arbiter #(.LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .count(count),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    logic         u1_ic_req, u1_ic_ack, u1_dc_ack, u1_mem_write, u1_busy;
    logic [31:0]  u1_ic_addr, u1_rd_addr, u1_wr_addr;
    logic [127:0] u1_ic_rdata, u1_dc_rdata, u1_wdata, u1_mem_rdata;
    logic [4:0]   u1_count;
    assign u1_mem_rdata = env_mem[u1_rd_addr[7:4]];

    mem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ic_req(u1_ic_req), .ic_addr(u1_ic_addr), .ic_ack(u1_ic_ack), .ic_rdata(u1_ic_rdata),
        .dc_req(1'b0), .dc_we(1'b0), .dc_addr(32'h0), .dc_wdata(128'h0),
        .dc_ack(u1_dc_ack), .dc_rdata(u1_dc_rdata),
        .mem_read_address(u1_rd_addr), .mem_write_address(u1_wr_addr),
        .mem_write_data(u1_wdata), .mem_write(u1_mem_write), .count(u1_count),
        .mem_read_data(u1_mem_rdata), .busy(u1_busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: the current transaction is described by its grant cycle and what was granted.
    int           m_n = -1000;
    int           m_free = 0;
    bit           m_dc, m_we, m_last_dc;
    logic [31:0]  m_addr;
    logic [127:0] m_wdata;
    logic [127:0] ref_mem [16];
    logic [127:0] exp_ic_rd, exp_dc_rd;

    int           n_ic_ack = 0, n_dc_ack = 0, n_wr = 0;
    int           last_ic_ack_cyc = 0, last_dc_ack_cyc = 0, last_wr_cyc = 0;
    logic [4:0]   last_wr_count = '0;
    int           u1_q[$];
    logic [127:0] u1_last_rd = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        int off;
        bit acc, ackc;
        off  = cyc - m_n;
        acc  = (off >= 1) && (off <= L);
        ackc = (off == L + 1);
        chk("busy", 128'(busy), 128'(acc || ackc));
        chk("ic_ack", 128'(ic_ack), 128'(ackc && !m_dc));
        chk("dc_ack", 128'(dc_ack), 128'(ackc && m_dc));
        chk("mem_write", 128'(mem_write), 128'(acc && m_we && off == L));
        chk("ic_rdata", ic_rdata, exp_ic_rd);
        chk("dc_rdata", dc_rdata, exp_dc_rd);
        if (acc) begin
            chk("count", 128'(count), 128'(off - 1));
            if (m_we) chk("wr_addr", 128'(mem_write_address), 128'(m_addr));
            else      chk("rd_addr", 128'(mem_read_address), 128'(m_addr));
            if (m_we && off == L) chk("wr_data", mem_write_data, m_wdata);
        end
        if (ic_ack === 1'b1) begin n_ic_ack++; last_ic_ack_cyc = cyc; end
        if (dc_ack === 1'b1) begin n_dc_ack++; last_dc_ack_cyc = cyc; end
        if (mem_write === 1'b1) begin
            n_wr++; last_wr_cyc = cyc; last_wr_count = count;
            env_mem[mem_write_address[7:4]] = mem_write_data;
        end
        if (u1_ic_ack === 1'b1) begin u1_q.push_back(cyc); u1_last_rd = u1_ic_rdata; end
    endtask

    task automatic model_end();
        if (cyc - m_n == L) begin
            if (m_we)      ref_mem[m_addr[7:4]] = m_wdata;
            else if (m_dc) exp_dc_rd = ref_mem[m_addr[7:4]];
            else           exp_ic_rd = ref_mem[m_addr[7:4]];
        end
    endtask

    task automatic model_grant();
        bit win_dc;
        if (rst) begin
            m_n = -1000; m_free = cyc + 1; m_last_dc = 1'b0;
            exp_ic_rd = '0; exp_dc_rd = '0;
            return;
        end
        if (cyc < m_free || !(ic_req || dc_req)) return;
        win_dc    = dc_req && (!ic_req || !RR || !m_last_dc);
        m_last_dc = win_dc;
        m_n       = cyc;
        m_free    = cyc + L + 2;
        m_dc      = win_dc;
        m_we      = win_dc && dc_we;
        m_addr    = (win_dc ? dc_addr : ic_addr) & 32'hFFFF_FFF0;
        m_wdata   = dc_wdata;
    endtask

    task automatic advance();
        if (cyc - m_n == L + 1) begin
            if (m_dc) dc_req = 1'b0;
            else      ic_req = 1'b0;
        end
        model_grant();
        @(negedge clk);
        cyc++;
        check_cycle();
        model_end();
    endtask

    task automatic advance_n(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    initial begin
        int c0, guard, ic0, dc0, wr0;
        rst = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        u1_ic_req = 1'b0; u1_ic_addr = '0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = env_mem[i];
        end
        exp_ic_rd = '0; exp_dc_rd = '0; m_last_dc = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_acks", 128'({ic_ack, dc_ack, mem_write}), 128'(0));
        chk("rst_ic_rdata", ic_rdata, 128'h0);
        chk("rst_dc_rdata", dc_rdata, 128'h0);
        chk("rst_addrs", {64'h0, mem_read_address, mem_write_address}, 128'h0);
        chk("rst_wdata", mem_write_data, 128'h0);

        rst = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (!ic_req && $urandom_range(0, 3) == 0) begin
                ic_req = 1'b1; ic_addr = $urandom;
            end
            if (!dc_req && $urandom_range(0, 3) == 0) begin
                dc_req = 1'b1; dc_we = $urandom_range(0, 1) == 1;
                dc_addr = $urandom; dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            advance();
        end

        guard = 0;
        while ((ic_req || dc_req || cyc < m_free) && guard < 100) begin
            advance(); guard++;
        end
        chk("drain_done", 128'(ic_req || dc_req || cyc < m_free), 128'(0));

        // I-cache read of an unaligned address
        env_mem[2] = LINE_A; ref_mem[2] = LINE_A;
        ic0 = n_ic_ack; dc0 = n_dc_ack;
        ic_addr = 32'h0000_0024; ic_req = 1'b1; c0 = cyc;
        advance_n(L + 2);
        chk("ic_ack_latency", 128'(last_ic_ack_cyc - c0), 128'(11));
        chk("ic_ack_once", 128'(n_ic_ack - ic0), 128'(1));
        chk("ic_no_dc_ack", 128'(n_dc_ack - dc0), 128'(0));
        chk("ic_line", ic_rdata, LINE_A);
        chk("ic_rd_addr_held", 128'(mem_read_address), 128'(32'h20));

        // D-cache write-back then fill of the same line
        wr0 = n_wr; dc0 = n_dc_ack;
        dc_addr = 32'h40; dc_we = 1'b1; dc_wdata = 128'h9; dc_req = 1'b1; c0 = cyc;
        advance_n(L + 2);
        chk("wr_cycle", 128'(last_wr_cyc - c0), 128'(10));
        chk("wr_count", 128'(last_wr_count), 128'(9));
        chk("wr_once", 128'(n_wr - wr0), 128'(1));
        chk("wr_mem", env_mem[4], 128'h9);
        dc_we = 1'b0; dc_req = 1'b1; c0 = cyc;
        advance_n(L + 2);
        chk("dc_fill_latency", 128'(last_dc_ack_cyc - c0), 128'(11));
        chk("dc_fill_data", dc_rdata, 128'h9);
        chk("dc_acks", 128'(n_dc_ack - dc0), 128'(2));

        // Reset in the middle of a write-back
        env_mem[5] = LINE_B; ref_mem[5] = LINE_B;
        wr0 = n_wr; dc0 = n_dc_ack;
        dc_addr = 32'h50; dc_we = 1'b1; dc_wdata = 128'hdead; dc_req = 1'b1;
        advance_n(6);
        chk("pre_rst_count", 128'(count), 128'(5));
        rst = 1'b1; dc_req = 1'b0;
        advance();
        chk("post_rst_busy", 128'(busy), 128'(0));
        chk("post_rst_count", 128'(count), 128'(0));
        rst = 1'b0;
        advance_n(14);
        chk("rst_no_write", 128'(n_wr - wr0), 128'(0));
        chk("rst_no_ack", 128'(n_dc_ack - dc0), 128'(0));
        chk("rst_mem_kept", env_mem[5], LINE_B);

        // Contention straight after reset: D-cache first under either scheme
        ic_addr = 32'h100; dc_addr = 32'h230; dc_we = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1; c0 = cyc;
        advance_n(2 * L + 4);
        chk("cont1_dc", 128'(last_dc_ack_cyc - c0), 128'(11));
        chk("cont1_ic", 128'(last_ic_ack_cyc - c0), 128'(23));

        dc_req = 1'b1;
        advance_n(L + 2);
        ic_req = 1'b1; dc_req = 1'b1; c0 = cyc;
        advance_n(2 * L + 4);
        chk("cont2_ic", 128'(last_ic_ack_cyc - c0), 128'(EXP_IC2));
        chk("cont2_dc", 128'(last_dc_ack_cyc - c0), 128'(EXP_DC2));

        // LATENCY=1 instance with a continuously held I-cache request
        env_mem[3] = LINE_C; ref_mem[3] = LINE_C;
        u1_ic_addr = 32'h35; u1_ic_req = 1'b1; c0 = cyc;
        advance_n(11);
        u1_ic_req = 1'b0;
        advance_n(3);
        chk("l1_ack_count", 128'(u1_q.size()), 128'(4));
        for (int i = 0; i < u1_q.size() && i < 4; i++)
            chk("l1_ack_cycle", 128'(u1_q[i] - c0), 128'(2 + 3 * i));
        chk("l1_line", u1_last_rd, LINE_C);
        chk("l1_idle", 128'(u1_busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
